// File: rtl/mixed_nested_rr_arbiter_pkg.sv
// mixedNestedInclude_package: shared beat sizing and the arbiter state encoding.
package mixedNestedInclude_package;
    localparam int DSIZE = 1;
    localparam int DSIZE2 = 2 * DSIZE;
    localparam int ARB_DATA_W = 32 * DSIZE2;
    localparam int ARB_MAX_BURST = 8;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
endpackage

// File: rtl/mixed_nested_rr_arbiter_pick.sv
// mixed_nested_rr_pick: combinational rotate-priority picker, first request at or after ptr_i.
module mixed_nested_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] j;
    // Scan farthest offset first so the closest request to ptr_i wins last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                any_o = 1'b1;
                idx_o = j;
            end
        end
    end
endmodule

// File: rtl/mixed_nested_rr_arbiter.sv
// mixed_nested_rr_arbiter: packet-level round-robin arbiter onto one registered output beat path.
module mixed_nested_rr_arbiter
    import mixedNestedInclude_package::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       out_vld,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    input  logic                       out_rdy,
    output logic                       busy,
    output logic                       burst_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    arb_state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic pick_any, room, acc, locked;
    logic out_vld_q, out_last_q, burst_err_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IW-1:0] out_src_q;
    mixed_nested_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i(req_vld),
        .ptr_i(rr_ptr_q),
        .any_o(pick_any),
        .idx_o(pick_idx)
    );
    assign locked = state_q == ARB_LOCKED;
    assign room = !out_vld_q || out_rdy;
    assign acc = locked && room && req_vld[grant_q];
    assign req_rdy = (locked && room) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q : '0;
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (!locked && pick_any) begin
            state_d = ARB_LOCKED;
            grant_d = pick_idx;
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q == CW'(MAX_BURST) ? beat_cnt_q : beat_cnt_q + CW'(1);
            if (req_last[grant_q]) begin
                state_d = ARB_IDLE;
                rr_ptr_d = grant_q == IW'(NUM_REQ - 1) ? '0 : grant_q + IW'(1);
                beat_cnt_d = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q <= '0;
            beat_cnt_q <= '0;
            out_vld_q <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_src_q <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            if (acc) begin
                out_vld_q <= 1'b1;
                out_data_q <= req_data[int'(grant_q) * DATA_W +: DATA_W];
                out_last_q <= req_last[grant_q];
                out_src_q <= grant_q;
            end else if (out_rdy) begin
                out_vld_q <= 1'b0;
            end
            // A beat arriving with the counter already saturated overruns the burst limit.
            if (acc && beat_cnt_q == CW'(MAX_BURST)) burst_err_q <= 1'b1;
        end
    end
    assign out_vld = out_vld_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign out_src = out_src_q;
    assign busy = locked || out_vld_q;
    assign burst_err = burst_err_q;
endmodule

// File: tb/tb_mixed_nested_rr_arbiter.sv
// tb_mixed_nested_rr_arbiter: directed checks of arbitration order, locking, backpressure, burst and reset.
module tb_mixed_nested_rr_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_vld = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_rdy;
    logic out_vld, out_last, out_rdy = 1'b1, busy, burst_err;
    logic [W-1:0] out_data;
    logic [1:0] out_src;
    int tests = 0;
    int fails = 0;
    mixed_nested_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
        .req_rdy(req_rdy), .out_vld(out_vld), .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .out_rdy(out_rdy), .busy(busy), .burst_err(burst_err)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input int i, input logic v, input logic [W-1:0] d, input logic l);
        req_vld[i] = v;
        req_data[i*W +: W] = d;
        req_last[i] = l;
    endtask
    initial begin
        int k, rcv;
        logic acc_in;
        tick;
        tick;
        chk("rst_out_vld", W'(out_vld), 0);
        chk("rst_req_rdy", W'(req_rdy), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_err", W'(burst_err), 0);
        rst = 1'b0;
        // single requester, 3-beat packet
        drive(0, 1, 64'h100, 0);
        chk("t1_idle_rdy", W'(req_rdy), 0);
        tick;
        chk("t1_lock_rdy", W'(req_rdy), 4'b0001);
        chk("t1_vld_c1", W'(out_vld), 0);
        chk("t1_busy_c1", W'(busy), 1);
        tick;
        chk("t1_b0_vld", W'(out_vld), 1);
        chk("t1_b0_data", out_data, 64'h100);
        chk("t1_b0_src", W'(out_src), 0);
        chk("t1_b0_last", W'(out_last), 0);
        drive(0, 1, 64'h101, 0);
        tick;
        chk("t1_b1_data", out_data, 64'h101);
        chk("t1_b1_last", W'(out_last), 0);
        drive(0, 1, 64'h102, 1);
        tick;
        chk("t1_b2_data", out_data, 64'h102);
        chk("t1_b2_last", W'(out_last), 1);
        chk("t1_b2_busy", W'(busy), 1);
        drive(0, 0, 0, 0);
        tick;
        chk("t1_drain_vld", W'(out_vld), 0);
        chk("t1_drain_busy", W'(busy), 0);
        // four requesters, continuous 1-beat packets, from a fresh pointer
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive(i, 1, 64'hA0 + W'(i), 1);
        for (int p = 0; p < 8; p++) begin
            tick;
            chk("t2_gap_vld", W'(out_vld), 0);
            chk("t2_grant_rdy", W'(req_rdy), W'(1) << (p % 4));
            tick;
            chk("t2_out_vld", W'(out_vld), 1);
            chk("t2_out_src", W'(out_src), W'(p % 4));
            chk("t2_out_data", out_data, 64'hA0 + W'(p % 4));
        end
        req_vld = '0;
        req_last = '0;
        tick;
        // req1 locked while req2 arrives mid-packet
        drive(1, 1, 64'hB0, 0);
        tick;
        chk("t3_lock_rdy", W'(req_rdy), 4'b0010);
        tick;
        chk("t3_b0_data", out_data, 64'hB0);
        chk("t3_b0_src", W'(out_src), 1);
        drive(1, 1, 64'hB1, 0);
        drive(2, 1, 64'hC0, 1);
        chk("t3_req2_waits", W'(req_rdy), 4'b0010);
        tick;
        chk("t3_b1_data", out_data, 64'hB1);
        drive(1, 1, 64'hB2, 0);
        tick;
        chk("t3_b2_data", out_data, 64'hB2);
        drive(1, 1, 64'hB3, 1);
        tick;
        chk("t3_b3_data", out_data, 64'hB3);
        chk("t3_b3_last", W'(out_last), 1);
        chk("t3_b3_src", W'(out_src), 1);
        drive(1, 0, 0, 0);
        chk("t3_idle_rdy", W'(req_rdy), 0);
        tick;
        chk("t3_lock2_rdy", W'(req_rdy), 4'b0100);
        tick;
        chk("t3_c0_data", out_data, 64'hC0);
        chk("t3_c0_src", W'(out_src), 2);
        drive(2, 0, 0, 0);
        tick;
        // 5-beat packet from req0 with out_rdy toggling 1010
        k = 0;
        rcv = 0;
        for (int c = 0; c < 40; c++) begin
            out_rdy = (c % 2) == 0;
            drive(0, k < 5, 64'hE0 + W'(k), k == 4);
            #1;
            acc_in = req_vld[0] && req_rdy[0];
            if (out_vld && out_rdy) begin
                chk("t4_data", out_data, 64'hE0 + W'(rcv));
                chk("t4_last", W'(out_last), W'(rcv == 4));
                rcv++;
            end
            tick;
            if (acc_in) k++;
        end
        chk("t4_sent", W'(k), 5);
        chk("t4_rcvd", W'(rcv), 5);
        chk("t4_busy", W'(busy), 0);
        out_rdy = 1'b1;
        drive(0, 0, 0, 0);
        tick;
        // 9-beat packet from req3 overruns MAX_BURST=8
        drive(3, 1, 64'hF0, 0);
        tick;
        for (int j = 0; j < 9; j++) begin
            drive(3, 1, 64'hF0 + W'(j), j == 8);
            tick;
            chk("t5_data", out_data, 64'hF0 + W'(j));
            chk("t5_err", W'(burst_err), W'(j == 8));
        end
        drive(3, 0, 0, 0);
        tick;
        tick;
        chk("t5_err_sticky", W'(burst_err), 1);
        chk("t5_busy", W'(busy), 0);
        // reset in the middle of a 4-beat packet from req2
        drive(2, 1, 64'hD0, 0);
        tick;
        tick;
        drive(2, 1, 64'hD1, 0);
        tick;
        chk("t6_pre_data", out_data, 64'hD1);
        rst = 1'b1;
        drive(2, 0, 0, 0);
        tick;
        chk("t6_rst_vld", W'(out_vld), 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_src", W'(out_src), 0);
        chk("t6_rst_busy", W'(busy), 0);
        chk("t6_rst_err", W'(burst_err), 0);
        chk("t6_rst_rdy", W'(req_rdy), 0);
        rst = 1'b0;
        drive(3, 1, 64'h30, 1);
        tick;
        chk("t6_lock3_rdy", W'(req_rdy), 4'b1000);
        tick;
        chk("t6_r3_data", out_data, 64'h30);
        chk("t6_r3_src", W'(out_src), 3);
        drive(3, 0, 0, 0);
        drive(0, 1, 64'h31, 1);
        drive(2, 1, 64'h32, 1);
        tick;
        chk("t6_wrap_rdy", W'(req_rdy), 4'b0001);
        tick;
        chk("t6_wrap_src", W'(out_src), 0);
        chk("t6_wrap_data", out_data, 64'h31);
        req_vld = '0;
        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
